// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder: the default operand width and the
// 2-bit encodings of the controller states.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_e;

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// FullAdder: the 1-bit full-adder cell used by the serial adder.
// PATH_DELAY is the cell's timing annotation; this model is zero-delay, so the
// parameter is only range-checked here and carried for the timing flow.
module FullAdder #(
  parameter int PATH_DELAY = 3
) (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  if (PATH_DELAY < 0) begin : g_bad_path_delay
    $error("FullAdder: PATH_DELAY must be non-negative");
  end

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial unsigned adder, one operand bit per clock through
// a single FullAdder cell, LSB first. Result appears WIDTH cycles after accept.
// Optional feature macro: SERIAL_ADD_OVF_EN adds the 'ovf' signed-overflow port.
//
// Handshake: an operand transfer happens on a rising edge where in_valid and
// in_ready are both 1; a result transfer happens on a rising edge where
// out_valid and out_ready are both 1. in_ready is high only in IDLE and
// out_valid only in DONE, so the two transfers never share a cycle; the
// producer may drop or change its request at any time without effect outside
// IDLE, and the result is held stable until it is taken.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int PATH_DELAY = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic [1:0]       dbg_state_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("serial_add_ctrl: WIDTH must be in 2..32");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef SERIAL_ADD_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic fa_s, fa_co;

  FullAdder #(
    .PATH_DELAY (PATH_DELAY)
  ) u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Next-state and datapath update: load on accept, one bit per SHIFT cycle, hold in DONE.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          carry_d  = cin;
          cnt_d    = '0;
          result_d = '0;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d    = 1'b0;
`endif
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        // New sum bit enters at the MSB so after WIDTH shifts bit 0 lines up.
        result_d = {fa_s, result_q[WIDTH-1:1]};
        carry_d  = fa_co;
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
`ifdef SERIAL_ADD_OVF_EN
          // carry_q is the carry into the MSB, fa_co the carry out of it.
          ovf_d   = carry_q ^ fa_co;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign sum         = result_q;
  assign cout        = carry_q;
  assign dbg_state_o = state_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf         = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl (WIDTH=8): directed cases, hold, mid-operation
// reset, then randomized traffic with random out_ready back-pressure.
module tb_serial_add_ctrl;
  import serial_add_pkg::*;

  localparam int W  = 8;
  localparam int PD = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic [1:0]   dbg_state;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // expected {ovf, cout, sum} and accept cycle of each issued operation
  logic [W+1:0] exp_q[$];
  int           acc_q[$];
  bit           force_low = 1'b0;

  serial_add_ctrl #(
    .WIDTH      (W),
    .PATH_DELAY (PD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sum         (sum),
    .cout        (cout),
`ifdef SERIAL_ADD_OVF_EN
    .ovf         (ovf),
`endif
    .dbg_state_o (dbg_state)
  );

  // clock / cycle counter (period 10 exceeds 2*PATH_DELAY)
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference: plain integer arithmetic on the operands
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    longint total, sx, sy, ss;
    logic [W-1:0] s;
    logic co, ov;
    total = longint'(x) + longint'(y) + longint'(c);
    s     = W'(total);
    co    = (total >> W) != 0;
    sx    = x[W-1] ? longint'(x) - (longint'(1) << W) : longint'(x);
    sy    = y[W-1] ? longint'(y) - (longint'(1) << W) : longint'(y);
    ss    = sx + sy + longint'(c);
    ov    = (ss > (longint'(1) << (W - 1)) - 1) || (ss < -(longint'(1) << (W - 1)));
    return {ov, co, s};
  endfunction

  // consumer back-pressure
  always @(posedge clk) begin
    #2;
    out_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // driver: junk requests while busy, real operands on the first cycle in IDLE
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      in_valid = 1'($urandom_range(0, 1));
      a        = W'($urandom);
      b        = W'($urandom);
      cin      = 1'($urandom_range(0, 1));
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    in_valid = 1'b1;
    a        = x;
    b        = y;
    cin      = c;
    @(posedge clk);
    #1;
    exp_q.push_back(model(x, y, c));
    acc_q.push_back(cyc);
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    cin      = 1'($urandom_range(0, 1));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      a        = W'($urandom);
      b        = W'($urandom);
      cin      = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((exp_q.size() != 0 || out_valid) && n < 2000);
    if (exp_q.size() != 0 || out_valid) check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  in_ready,  1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_sum"},       sum,       0);
    check({tag, "_cout"},      cout,      0);
    check({tag, "_state"},     dbg_state, ST_IDLE);
`ifdef SERIAL_ADD_OVF_EN
    check({tag, "_ovf"},       ovf,       0);
`endif
  endtask

  // scoreboard monitor
  logic [W+1:0] cur_exp;
  bit           in_result   = 1'b0;
  bit           expect_idle = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      in_result   = 1'b0;
      expect_idle = 1'b0;
    end else begin
      if (expect_idle) begin
        check("in_ready_after_handoff",  in_ready,  1);
        check("out_valid_after_handoff", out_valid, 0);
        expect_idle = 1'b0;
      end
      if (out_valid) begin
        if (!in_result) begin
          check("pending_result", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            cur_exp   = exp_q.pop_front();
            check("latency", cyc - acc_q.pop_front(), W);
            in_result = 1'b1;
          end
        end
        if (in_result) begin
          check("sum",  sum,  cur_exp[W-1:0]);
          check("cout", cout, cur_exp[W]);
`ifdef SERIAL_ADD_OVF_EN
          check("ovf",  ovf,  cur_exp[W+1]);
`endif
          check("in_ready_low_in_done", in_ready, 0);
          if (out_ready) begin
            in_result   = 1'b0;
            expect_idle = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    int n;
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // directed operands
    send(8'h5A, 8'h33, 1'b0);
    send(8'hFF, 8'h01, 1'b0);
    send(8'hFF, 8'h00, 1'b1);
    send(8'h7F, 8'h01, 1'b0);
    send(8'h80, 8'h80, 1'b0);
    send(8'h00, 8'h00, 1'b0);
    wait_drain();

    // result held under back-pressure
    force_low = 1'b1;
    send(8'hC3, 8'h3C, 1'b1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("hold_result_seen", out_valid, 1);
    repeat (6) @(posedge clk);
    force_low = 1'b0;
    wait_drain();

    // reset in the 4th SHIFT cycle discards the operation
    send(8'h12, 8'h34, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(2 * W + 4);
    send(8'h01, 8'h02, 1'b0);
    wait_drain();

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      idle_cycles($urandom_range(0, 2));
      send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    end
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits, legal range 2..32.
REQ-002 SHALL have parameter PATH_DELAY, default 3, passed unchanged to the full-adder cell.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand request valid.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  WIDTH  operand A, unsigned.
REQ-008 SHALL have port b  input  WIDTH  operand B, unsigned.
REQ-009 SHALL have port cin  input  1  carry-in.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port sum  output  WIDTH  registered result, a+b+cin mod 2^WIDTH.
REQ-013 SHALL have port cout  output  1  registered carry-out of bit WIDTH-1.

Function
REQ-014 SHALL implement the states IDLE, SHIFT and DONE, encoded as 2-bit localparams.
REQ-015 SHALL drive in_ready=1 only in IDLE and drive out_valid=1 only in DONE, both decoded from registered state.
REQ-016 SHALL, on an edge in IDLE with in_valid=1, load the a/b shift registers, set carry<=cin, clear cnt and the result register, and go to SHIFT.
REQ-017 SHALL, on each SHIFT edge, add bit 0 of both operand registers and carry in one full-adder instance.
  - the FA sum bit enters result bit WIDTH-1 and the result register shifts right;
  - carry<=FA cout; both operand registers shift right; cnt<=cnt+1.
REQ-018 SHALL leave SHIFT for DONE on the edge where cnt==WIDTH-1, so that out_valid rises exactly WIDTH cycles after the accept edge.
REQ-019 SHALL hold sum and cout stable in DONE for as long as out_ready=0, for any number of cycles.
REQ-020 SHALL return from DONE to IDLE on an edge with out_ready=1.
  - in_ready is therefore low in that cycle, and no accept can occur in the same cycle as result hand-off.
REQ-021 SHALL ignore in_valid, a, b and cin outside IDLE; operands SHALL be sampled only on the accept edge.
REQ-022 SHALL size cnt as $clog2(WIDTH) bits; wrap-around SHALL never be reached because the exit condition is WIDTH-1.
REQ-023 SHALL drive cout from the carry register after the final SHIFT edge, and sum from the result register.

Reset
REQ-024 SHALL, while rst=1 at any time including mid-SHIFT or DONE, force state=IDLE, cnt=0, carry=0, operand/result registers=0, sum=0, cout=0, out_valid=0, in_ready=1.
REQ-025 SHALL discard any in-progress operation on reset, with no partial result emitted afterwards.

Configuration
REQ-026 SHALL, when SERIAL_ADD_OVF_EN is defined, add output port ovf (1 bit), which is the signed overflow: carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - ovf is registered at the final SHIFT edge, valid with out_valid, and reset to 0.
REQ-027 SHALL, when SERIAL_ADD_OVF_EN is undefined, omit the ovf port and its register entirely, with all other behaviour identical.

Structure
REQ-028 SHALL take the state encodings and the DEFAULT_WIDTH constant from shared include file serial_add_pkg.vh.
REQ-029 SHALL instantiate exactly one sub-module: FullAdder, the existing 1-bit cell, with PATH_DELAY forwarded.
  - the clock period SHALL exceed 2*PATH_DELAY.

Verification
REQ-030 SHALL pass, with WIDTH=8: a=0x5A, b=0x33, cin=0, out_ready=1 -> out_valid 8 cycles after accept, sum=0x8D, cout=0, then in_ready=1 the cycle after.
REQ-031 SHALL pass: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; and separately a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
REQ-032 SHALL pass: result ready with out_ready=0 for 5 cycles -> out_valid and sum/cout unchanged all 5 cycles; out_ready=1 -> IDLE next edge.
REQ-033 SHALL pass: rst pulsed during the 4th SHIFT cycle of 0x12+0x34 -> all outputs 0 and in_ready=1 immediately, and no out_valid follows; a new 0x01+0x02 then gives sum=0x03.
REQ-034 SHALL pass, with SERIAL_ADD_OVF_EN: a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1; and a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.
REQ-035 SHALL pass: a, b and cin changed every cycle during SHIFT -> result equals the values sampled at the accept edge.
